// File: rtl/apb2axi_tag_sched.sv
// Tag pool scheduler for the APB2AXI converter: allocates tags on command commit,
// issues them round-robin to the AXI request builder, and retires them on completion and release.
module apb2axi_tag_sched #(
  parameter int TAG_NUM    = 16,
  parameter int TAG_W      = $clog2(TAG_NUM),
  parameter int MAX_OUT_RD = 8,
  parameter int MAX_OUT_WR = 8,
  parameter int CNT_W      = $clog2(TAG_NUM + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  input  logic                 alloc_is_write,
  output logic                 alloc_gnt,
  output logic [TAG_W-1:0]     alloc_tag,
  output logic                 full,
  output logic                 issue_valid,
  output logic [TAG_W-1:0]     issue_tag,
  output logic                 issue_is_write,
  input  logic                 issue_ready,
  input  logic                 cpl_valid,
  input  logic [TAG_W-1:0]     cpl_tag,
  input  logic [1:0]           cpl_resp,
  input  logic                 rel_valid,
  input  logic [TAG_W-1:0]     rel_tag,
  output logic [2*TAG_NUM-1:0] tag_state,
  output logic [2*TAG_NUM-1:0] tag_resp,
  output logic [CNT_W-1:0]     free_cnt,
  output logic [CNT_W-1:0]     rd_out_cnt,
  output logic [CNT_W-1:0]     wr_out_cnt,
  output logic                 proto_err
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_ALLOCATED = 2'd1,
    ST_PENDING   = 2'd2,
    ST_COMPLETE  = 2'd3
  } entry_state_e;

  entry_state_e       st_q   [TAG_NUM];
  entry_state_e       st_d   [TAG_NUM];
  logic [1:0]         resp_q [TAG_NUM];
  logic [1:0]         resp_d [TAG_NUM];
  logic [TAG_NUM-1:0] wr_q, wr_d;
  logic [TAG_W-1:0]   rr_q, rr_d;
  logic               issue_valid_d, issue_is_write_d;
  logic [TAG_W-1:0]   issue_tag_d;
  logic [CNT_W-1:0]   free_d, rd_d, wr_d_cnt;
  logic               proto_err_d;

  logic               found_empty;
  logic [TAG_W-1:0]   empty_idx;
  logic               sel_hit;
  logic [TAG_W-1:0]   sel_idx, cand;
  logic               rd_block, wr_block;
  logic               hs, cpl_ok, rel_ok;

  // Lowest-index EMPTY tag, looked up from registered state only.
  always_comb begin
    found_empty = 1'b0;
    empty_idx   = '0;
    for (int i = TAG_NUM - 1; i >= 0; i--) begin
      if (st_q[i] == ST_EMPTY) begin
        found_empty = 1'b1;
        empty_idx   = TAG_W'(i);
      end
    end
  end

  assign full      = ~found_empty;
  assign alloc_gnt = alloc_req & found_empty;
  assign alloc_tag = empty_idx;

  // Round-robin scan of ALLOCATED tags from rr_q, skipping a direction at its outstanding limit.
  always_comb begin
    sel_hit  = 1'b0;
    sel_idx  = '0;
    cand     = '0;
    rd_block = (rd_out_cnt >= CNT_W'(MAX_OUT_RD));
    wr_block = (wr_out_cnt >= CNT_W'(MAX_OUT_WR));
    for (int k = 0; k < TAG_NUM; k++) begin
      cand = TAG_W'((int'(rr_q) + k) % TAG_NUM);
      if (!sel_hit && st_q[cand] == ST_ALLOCATED &&
          (wr_q[cand] ? !wr_block : !rd_block)) begin
        sel_hit = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Issue handshake: a transfer happens on a cycle with issue_valid & issue_ready; once
  // raised, issue_valid stays high with issue_tag/issue_is_write frozen until that transfer.
  assign hs     = issue_valid & issue_ready;
  assign cpl_ok = cpl_valid && (st_q[cpl_tag] == ST_PENDING);
  assign rel_ok = rel_valid && (st_q[rel_tag] == ST_COMPLETE);

  always_comb begin
    st_d             = st_q;
    resp_d           = resp_q;
    wr_d             = wr_q;
    rr_d             = rr_q;
    issue_valid_d    = issue_valid;
    issue_tag_d      = issue_tag;
    issue_is_write_d = issue_is_write;

    if (alloc_gnt) begin
      st_d[alloc_tag] = ST_ALLOCATED;
      wr_d[alloc_tag] = alloc_is_write;
    end

    if (hs) begin
      st_d[issue_tag] = ST_PENDING;
      rr_d            = (issue_tag == TAG_W'(TAG_NUM - 1)) ? '0 : issue_tag + TAG_W'(1);
      issue_valid_d   = 1'b0;
    end else if (!issue_valid && sel_hit) begin
      issue_valid_d    = 1'b1;
      issue_tag_d      = sel_idx;
      issue_is_write_d = wr_q[sel_idx];
    end

    if (cpl_ok) begin
      st_d[cpl_tag]   = ST_COMPLETE;
      resp_d[cpl_tag] = cpl_resp;
    end
    if (rel_ok) begin
      st_d[rel_tag] = ST_EMPTY;
    end

    rd_d     = rd_out_cnt + CNT_W'(hs & ~issue_is_write) - CNT_W'(cpl_ok & ~wr_q[cpl_tag]);
    wr_d_cnt = wr_out_cnt + CNT_W'(hs & issue_is_write) - CNT_W'(cpl_ok & wr_q[cpl_tag]);
    free_d   = free_cnt + CNT_W'(rel_ok) - CNT_W'(alloc_gnt);
    // Illegal completion and illegal release in the same cycle share one pulse.
    proto_err_d = (cpl_valid & ~cpl_ok) | (rel_valid & ~rel_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_NUM; i++) begin
        st_q[i]   <= ST_EMPTY;
        resp_q[i] <= 2'b00;
      end
      wr_q           <= '0;
      rr_q           <= '0;
      issue_valid    <= 1'b0;
      issue_tag      <= '0;
      issue_is_write <= 1'b0;
      free_cnt       <= CNT_W'(TAG_NUM);
      rd_out_cnt     <= '0;
      wr_out_cnt     <= '0;
      proto_err      <= 1'b0;
    end else begin
      for (int i = 0; i < TAG_NUM; i++) begin
        st_q[i]   <= st_d[i];
        resp_q[i] <= resp_d[i];
      end
      wr_q           <= wr_d;
      rr_q           <= rr_d;
      issue_valid    <= issue_valid_d;
      issue_tag      <= issue_tag_d;
      issue_is_write <= issue_is_write_d;
      free_cnt       <= free_d;
      rd_out_cnt     <= rd_d;
      wr_out_cnt     <= wr_d_cnt;
      proto_err      <= proto_err_d;
    end
  end

  for (genvar g = 0; g < TAG_NUM; g++) begin : g_dbg
    assign tag_state[2*g +: 2] = st_q[g];
    assign tag_resp[2*g +: 2]  = resp_q[g];
  end

endmodule

// File: tb/tb_apb2axi_tag_sched.sv
// Bench for apb2axi_tag_sched: directed scenarios plus a randomized run against a tag-table model.
module tb_apb2axi_tag_sched;
  localparam int TAG_NUM = 16;
  localparam int TAG_W   = 4;
  localparam int CNT_W   = 5;
  localparam int MAX_RD  = 2;
  localparam int MAX_WR  = 3;

  logic                 clk, rst;
  logic                 alloc_req, alloc_is_write, alloc_gnt, full;
  logic [TAG_W-1:0]     alloc_tag, issue_tag, cpl_tag, rel_tag;
  logic                 issue_valid, issue_is_write, issue_ready;
  logic                 cpl_valid, rel_valid, proto_err;
  logic [1:0]           cpl_resp;
  logic [2*TAG_NUM-1:0] tag_state, tag_resp;
  logic [CNT_W-1:0]     free_cnt, rd_out_cnt, wr_out_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: 0 empty, 1 allocated, 2 pending, 3 complete
  int m_st   [TAG_NUM];
  bit m_wr   [TAG_NUM];
  int m_resp [TAG_NUM];
  bit m_iv, m_iwr, m_perr;
  int m_itag, m_rr;

  apb2axi_tag_sched #(.TAG_NUM(TAG_NUM), .MAX_OUT_RD(MAX_RD), .MAX_OUT_WR(MAX_WR)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_is_write(alloc_is_write),
    .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .full(full),
    .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_is_write(issue_is_write),
    .issue_ready(issue_ready),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_resp(cpl_resp),
    .rel_valid(rel_valid), .rel_tag(rel_tag),
    .tag_state(tag_state), .tag_resp(tag_resp),
    .free_cnt(free_cnt), .rd_out_cnt(rd_out_cnt), .wr_out_cnt(wr_out_cnt),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int count_st(int s);
    int n = 0;
    for (int i = 0; i < TAG_NUM; i++) if (m_st[i] == s) n++;
    return n;
  endfunction

  function automatic int count_pend(bit w);
    int n = 0;
    for (int i = 0; i < TAG_NUM; i++) if (m_st[i] == 2 && m_wr[i] == w) n++;
    return n;
  endfunction

  function automatic int lowest_empty();
    for (int i = 0; i < TAG_NUM; i++) if (m_st[i] == 0) return i;
    return -1;
  endfunction

  function automatic logic [2*TAG_NUM-1:0] exp_state();
    logic [2*TAG_NUM-1:0] v = '0;
    for (int i = 0; i < TAG_NUM; i++) v[2*i +: 2] = 2'(m_st[i]);
    return v;
  endfunction

  function automatic logic [2*TAG_NUM-1:0] exp_resp();
    logic [2*TAG_NUM-1:0] v = '0;
    for (int i = 0; i < TAG_NUM; i++) v[2*i +: 2] = 2'(m_resp[i]);
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < TAG_NUM; i++) begin
      m_st[i] = 0; m_wr[i] = 1'b0; m_resp[i] = 0;
    end
    m_iv = 1'b0; m_iwr = 1'b0; m_perr = 1'b0; m_itag = 0; m_rr = 0;
  endtask

  task automatic clear_inputs();
    alloc_req = 1'b0; alloc_is_write = 1'b0; issue_ready = 1'b0;
    cpl_valid = 1'b0; cpl_tag = '0; cpl_resp = 2'b00;
    rel_valid = 1'b0; rel_tag = '0;
  endtask

  // Advance one clock: predict the next model state from the current inputs, then drop one-shot inputs.
  task automatic tick();
    int  st_n [TAG_NUM];
    bit  wr_n [TAG_NUM];
    int  resp_n [TAG_NUM];
    bit  iv_n, iwr_n, cpl_ok, rel_ok, found;
    int  itag_n, rr_n, g, rd_p, wr_p, t;
    st_n = m_st; wr_n = m_wr; resp_n = m_resp;
    iv_n = m_iv; iwr_n = m_iwr; itag_n = m_itag; rr_n = m_rr;
    g      = lowest_empty();
    cpl_ok = cpl_valid && m_st[cpl_tag] == 2;
    rel_ok = rel_valid && m_st[rel_tag] == 3;
    if (alloc_req && g >= 0) begin st_n[g] = 1; wr_n[g] = alloc_is_write; end
    if (m_iv && issue_ready) begin
      st_n[m_itag] = 2; rr_n = (m_itag + 1) % TAG_NUM; iv_n = 1'b0;
    end
    if (cpl_ok) begin st_n[cpl_tag] = 3; resp_n[cpl_tag] = int'(cpl_resp); end
    if (rel_ok) st_n[rel_tag] = 0;
    if (!m_iv) begin
      rd_p = count_pend(1'b0); wr_p = count_pend(1'b1); found = 1'b0;
      for (int k = 0; k < TAG_NUM; k++) begin
        t = (m_rr + k) % TAG_NUM;
        if (!found && m_st[t] == 1 && (m_wr[t] ? (wr_p < MAX_WR) : (rd_p < MAX_RD))) begin
          found = 1'b1; iv_n = 1'b1; itag_n = t; iwr_n = m_wr[t];
        end
      end
    end
    m_perr = (cpl_valid && !cpl_ok) || (rel_valid && !rel_ok);
    @(posedge clk); #1;
    m_st = st_n; m_wr = wr_n; m_resp = resp_n;
    m_iv = iv_n; m_iwr = iwr_n; m_itag = itag_n; m_rr = rr_n;
    alloc_req = 1'b0; cpl_valid = 1'b0; rel_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (issue_valid !== 1'b0 || issue_tag !== '0 || issue_is_write !== 1'b0) begin
      failures++; $display("FAIL reset_issue: valid=%b tag=%0d wr=%b required 0/0/0", issue_valid, issue_tag, issue_is_write);
    end
    checks++;
    if (free_cnt !== CNT_W'(16) || rd_out_cnt !== '0 || wr_out_cnt !== '0) begin
      failures++; $display("FAIL reset_counters: free=%0d rd=%0d wr=%0d required 16/0/0", free_cnt, rd_out_cnt, wr_out_cnt);
    end
    checks++;
    if (tag_state !== '0 || tag_resp !== '0 || full !== 1'b0 || proto_err !== 1'b0 || alloc_gnt !== 1'b0) begin
      failures++; $display("FAIL reset_state: state=%h resp=%h full=%b perr=%b gnt=%b required all 0", tag_state, tag_resp, full, proto_err, alloc_gnt);
    end
  endtask

  task automatic test_basic_order();
    bit dirs[3] = '{1'b0, 1'b1, 1'b0};
    int seen_tag[$];
    int seen_cyc[$];
    bit seen_wr[$];
    int cyc = 0;
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alloc_req = 1'b1; alloc_is_write = dirs[i];
      #1;
      checks++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== TAG_W'(i)) begin
        failures++; $display("FAIL basic_grant_%0d: gnt=%b tag=%0d required 1/%0d", i, alloc_gnt, alloc_tag, i);
      end
      if (issue_valid) begin seen_tag.push_back(int'(issue_tag)); seen_cyc.push_back(cyc); seen_wr.push_back(issue_is_write); end
      tick(); cyc++;
    end
    checks++;
    if (free_cnt !== CNT_W'(13)) begin
      failures++; $display("FAIL basic_free_cnt: got %0d required 13", free_cnt);
    end
    for (int n = 0; n < 10; n++) begin
      if (issue_valid) begin seen_tag.push_back(int'(issue_tag)); seen_cyc.push_back(cyc); seen_wr.push_back(issue_is_write); end
      tick(); cyc++;
    end
    checks++;
    if (seen_tag.size() != 3) begin
      failures++; $display("FAIL basic_issue_count: got %0d required 3", seen_tag.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (seen_tag[i] != i || seen_wr[i] != dirs[i]) begin
          failures++; $display("FAIL basic_issue_%0d: tag=%0d wr=%b required %0d/%b", i, seen_tag[i], seen_wr[i], i, dirs[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (seen_cyc[i] - seen_cyc[i-1] != 2) begin
          failures++; $display("FAIL basic_issue_gap_%0d: got %0d cycles required 2", i, seen_cyc[i] - seen_cyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_read_limit();
    bit dirs[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2*TAG_NUM-1:0] want;
    int n;
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1; alloc_is_write = dirs[i];
      tick();
    end
    repeat (12) tick();
    want = '0;
    want[1:0] = 2'd2; want[3:2] = 2'd2; want[5:4] = 2'd1; want[7:6] = 2'd2;
    checks++;
    if (tag_state !== want || issue_valid !== 1'b0) begin
      failures++; $display("FAIL limit_stall: state=%h valid=%b required %h/0", tag_state, issue_valid, want);
    end
    checks++;
    if (rd_out_cnt !== CNT_W'(2) || wr_out_cnt !== CNT_W'(1)) begin
      failures++; $display("FAIL limit_counts: rd=%0d wr=%0d required 2/1", rd_out_cnt, wr_out_cnt);
    end
    cpl_valid = 1'b1; cpl_tag = 4'd0; cpl_resp = 2'b10;
    tick();
    checks++;
    if (tag_resp[1:0] !== 2'b10 || tag_state[1:0] !== 2'd3) begin
      failures++; $display("FAIL limit_cpl: resp=%b state=%0d required 10/3", tag_resp[1:0], tag_state[1:0]);
    end
    for (n = 0; n < 6 && !issue_valid; n++) tick();
    checks++;
    if (issue_valid !== 1'b1 || issue_tag !== 4'd2 || issue_is_write !== 1'b0) begin
      failures++; $display("FAIL limit_resume: valid=%b tag=%0d wr=%b required 1/2/0", issue_valid, issue_tag, issue_is_write);
    end
  endtask

  task automatic test_full();
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < TAG_NUM; i++) begin
      alloc_req = 1'b1; alloc_is_write = (i < 5);
      #1;
      checks++;
      if (alloc_gnt !== 1'b1 || alloc_tag !== TAG_W'(i)) begin
        failures++; $display("FAIL full_grant_%0d: gnt=%b tag=%0d required 1/%0d", i, alloc_gnt, alloc_tag, i);
      end
      tick();
    end
    repeat (16) tick();
    alloc_req = 1'b1; alloc_is_write = 1'b0;
    #1;
    checks++;
    if (full !== 1'b1 || free_cnt !== '0 || alloc_gnt !== 1'b0) begin
      failures++; $display("FAIL full_flags: full=%b free=%0d gnt=%b required 1/0/0", full, free_cnt, alloc_gnt);
    end
    tick();
    checks++;
    if (tag_state[11:10] !== 2'd2) begin
      failures++; $display("FAIL full_tag5_pending: state=%0d required 2", tag_state[11:10]);
    end
    cpl_valid = 1'b1; cpl_tag = 4'd5; cpl_resp = 2'b01;
    tick();
    rel_valid = 1'b1; rel_tag = 4'd5; alloc_req = 1'b1;
    #1;
    checks++;
    if (alloc_gnt !== 1'b0) begin
      failures++; $display("FAIL full_release_same_cycle: gnt=%b required 0", alloc_gnt);
    end
    tick();
    alloc_req = 1'b1; alloc_is_write = 1'b1;
    #1;
    checks++;
    if (free_cnt !== CNT_W'(1) || alloc_gnt !== 1'b1 || alloc_tag !== 4'd5) begin
      failures++; $display("FAIL full_realloc: free=%0d gnt=%b tag=%0d required 1/1/5", free_cnt, alloc_gnt, alloc_tag);
    end
    tick();
    checks++;
    if (free_cnt !== '0 || tag_state[11:10] !== 2'd1) begin
      failures++; $display("FAIL full_after_realloc: free=%0d state5=%0d required 0/1", free_cnt, tag_state[11:10]);
    end
  endtask

  task automatic test_hold();
    bit dir;
    int n;
    do_reset();
    dir = 1'($urandom_range(0, 1));
    alloc_req = 1'b1; alloc_is_write = dir;
    tick();
    for (n = 0; n < 4 && !issue_valid; n++) tick();
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (issue_valid !== 1'b1 || issue_tag !== 4'd0 || issue_is_write !== dir ||
          rd_out_cnt !== '0 || wr_out_cnt !== '0) begin
        failures++; $display("FAIL hold_cycle_%0d: valid=%b tag=%0d wr=%b rd=%0d wrc=%0d required 1/0/%b/0/0",
                             c, issue_valid, issue_tag, issue_is_write, rd_out_cnt, wr_out_cnt, dir);
      end
      tick();
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    checks++;
    if (tag_state[1:0] !== 2'd2 || issue_valid !== 1'b0 ||
        (dir ? wr_out_cnt : rd_out_cnt) !== CNT_W'(1)) begin
      failures++; $display("FAIL hold_release: state=%0d valid=%b rd=%0d wr=%0d required 2/0 count 1 for wr=%b",
                           tag_state[1:0], issue_valid, rd_out_cnt, wr_out_cnt, dir);
    end
  endtask

  task automatic test_proto_err();
    logic [2*TAG_NUM-1:0] want;
    int n;
    do_reset();
    issue_ready = 1'b1;
    alloc_req = 1'b1; alloc_is_write = 1'b0;
    tick();
    repeat (4) tick();
    want = '0; want[1:0] = 2'd2;
    cpl_valid = 1'b1; cpl_tag = 4'd7; cpl_resp = 2'b11;
    tick();
    checks++;
    if (proto_err !== 1'b1 || tag_state !== want || tag_resp !== '0) begin
      failures++; $display("FAIL perr_cpl_empty: perr=%b state=%h resp=%h required 1/%h/0", proto_err, tag_state, tag_resp, want);
    end
    tick();
    checks++;
    if (proto_err !== 1'b0) begin
      failures++; $display("FAIL perr_pulse_width: perr=%b required 0", proto_err);
    end
    rel_valid = 1'b1; rel_tag = 4'd0;
    tick();
    checks++;
    if (proto_err !== 1'b1 || tag_state !== want) begin
      failures++; $display("FAIL perr_rel_pending: perr=%b state=%h required 1/%h", proto_err, tag_state, want);
    end
    cpl_valid = 1'b1; cpl_tag = 4'd7; rel_valid = 1'b1; rel_tag = 4'd0;
    tick();
    checks++;
    if (proto_err !== 1'b1) begin
      failures++; $display("FAIL perr_both: perr=%b required 1", proto_err);
    end
    tick();
    checks++;
    if (proto_err !== 1'b0) begin
      failures++; $display("FAIL perr_both_single: perr=%b required 0", proto_err);
    end
    issue_ready = 1'b0;
    alloc_req = 1'b1; alloc_is_write = 1'b1;
    tick();
    for (n = 0; n < 4 && !issue_valid; n++) tick();
    issue_ready = 1'b1; cpl_valid = 1'b1; cpl_tag = 4'd1; cpl_resp = 2'b10;
    tick();
    issue_ready = 1'b0;
    checks++;
    if (proto_err !== 1'b1 || tag_state[3:2] !== 2'd2 || wr_out_cnt !== CNT_W'(1) || tag_resp[3:2] !== 2'b00) begin
      failures++; $display("FAIL perr_cpl_on_issue: perr=%b state1=%0d wr=%0d resp1=%b required 1/2/1/00",
                           proto_err, tag_state[3:2], wr_out_cnt, tag_resp[3:2]);
    end
  endtask

  task automatic test_reset_midrun();
    bit dirs[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int n;
    do_reset();
    issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alloc_req = 1'b1; alloc_is_write = dirs[i];
      tick();
    end
    repeat (10) tick();
    cpl_valid = 1'b1; cpl_tag = 4'd0; cpl_resp = 2'b11;
    issue_ready = 1'b0;
    alloc_req = 1'b1; alloc_is_write = 1'b1;
    tick();
    for (n = 0; n < 4 && !issue_valid; n++) tick();
    checks++;
    if (issue_valid !== 1'b1 || rd_out_cnt !== CNT_W'(1) || wr_out_cnt !== CNT_W'(2)) begin
      failures++; $display("FAIL midrun_setup: valid=%b rd=%0d wr=%0d required 1/1/2", issue_valid, rd_out_cnt, wr_out_cnt);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++; $display("FAIL midrun_async_valid: valid=%b required 0", issue_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (tag_state !== '0 || tag_resp !== '0 || free_cnt !== CNT_W'(16) || rd_out_cnt !== '0 ||
        wr_out_cnt !== '0 || issue_tag !== '0 || issue_is_write !== 1'b0 || proto_err !== 1'b0) begin
      failures++; $display("FAIL midrun_reset_values: state=%h resp=%h free=%0d rd=%0d wr=%0d tag=%0d iw=%b perr=%b required 0/0/16/0/0/0/0/0",
                           tag_state, tag_resp, free_cnt, rd_out_cnt, wr_out_cnt, issue_tag, issue_is_write, proto_err);
    end
    rst = 1'b0;
    clear_inputs();
    m_reset();
  endtask

  task automatic test_random();
    int cands[$];
    int g;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      alloc_req      = ($urandom_range(0, 1) == 1);
      alloc_is_write = 1'($urandom_range(0, 1));
      issue_ready    = ($urandom_range(0, 3) != 0);
      cpl_valid      = ($urandom_range(0, 2) == 0);
      cpl_resp       = 2'($urandom_range(0, 3));
      cpl_tag        = TAG_W'($urandom_range(0, TAG_NUM - 1));
      cands.delete();
      for (int i = 0; i < TAG_NUM; i++) if (m_st[i] == 2) cands.push_back(i);
      if (cands.size() > 0 && $urandom_range(0, 4) != 0) cpl_tag = TAG_W'(cands[$urandom_range(0, cands.size() - 1)]);
      rel_valid = ($urandom_range(0, 2) == 0);
      rel_tag   = TAG_W'($urandom_range(0, TAG_NUM - 1));
      cands.delete();
      for (int i = 0; i < TAG_NUM; i++) if (m_st[i] == 3) cands.push_back(i);
      if (cands.size() > 0 && $urandom_range(0, 4) != 0) rel_tag = TAG_W'(cands[$urandom_range(0, cands.size() - 1)]);
      #1;
      g = lowest_empty();
      checks++;
      if (alloc_gnt !== (alloc_req && g >= 0) || full !== (g < 0) || (g >= 0 && alloc_tag !== TAG_W'(g))) begin
        failures++; $display("FAIL rand_alloc c%0d: gnt=%b full=%b tag=%0d required lowest empty %0d req=%b", c, alloc_gnt, full, alloc_tag, g, alloc_req);
      end
      checks++;
      if (issue_valid !== m_iv || (m_iv && (issue_tag !== TAG_W'(m_itag) || issue_is_write !== m_iwr))) begin
        failures++; $display("FAIL rand_issue c%0d: valid=%b tag=%0d wr=%b required %b/%0d/%b", c, issue_valid, issue_tag, issue_is_write, m_iv, m_itag, m_iwr);
      end
      checks++;
      if (tag_state !== exp_state() || tag_resp !== exp_resp()) begin
        failures++; $display("FAIL rand_table c%0d: state=%h resp=%h required %h/%h", c, tag_state, tag_resp, exp_state(), exp_resp());
      end
      checks++;
      if (free_cnt !== CNT_W'(count_st(0)) || rd_out_cnt !== CNT_W'(count_pend(1'b0)) || wr_out_cnt !== CNT_W'(count_pend(1'b1))) begin
        failures++; $display("FAIL rand_counts c%0d: free=%0d rd=%0d wr=%0d required %0d/%0d/%0d", c, free_cnt, rd_out_cnt, wr_out_cnt,
                             count_st(0), count_pend(1'b0), count_pend(1'b1));
      end
      checks++;
      if (proto_err !== m_perr) begin
        failures++; $display("FAIL rand_proto_err c%0d: got %b required %b", c, proto_err, m_perr);
      end
      tick();
    end
    issue_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_basic_order();
    test_read_limit();
    test_full();
    test_hold();
    test_proto_err();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
